min_sec_countdown: RTL and testbench

//  BCD MM:SS countdown timer; counts in the opposite direction to the clock's up-counters.

---
 rtl/min_sec_countdown.sv | 147 ++++++++++++++
 tb/tb_min_sec_countdown.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/min_sec_countdown.sv
// BCD MM:SS countdown timer: preset load, 1 Hz decrement in RUN, stop at 00:00,
// then hold ALARM for ALARM_TICKS ticks. State changes take effect on the clock edge that samples the inputs.
module min_sec_countdown #(
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       tick_i,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [2:0] ld_mh_i,
  input  logic [3:0] ld_ml_i,
  input  logic [2:0] ld_sh_i,
  input  logic [3:0] ld_sl_i,
  input  logic       start_i,
  input  logic       stop_i,
  output logic [2:0] mh_o,
  output logic [3:0] ml_o,
  output logic [2:0] sh_o,
  output logic [3:0] sl_o,
  output logic       busy_o,
  output logic       zero_p_o,
  output logic       alarm_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_e;

  localparam logic [7:0] ALARM_LIMIT = 8'(ALARM_TICKS);

  state_e     state_q, state_d;
  logic [2:0] mh_q, mh_d;
  logic [3:0] ml_q, ml_d;
  logic [2:0] sh_q, sh_d;
  logic [3:0] sl_q, sl_d;
  logic [7:0] alarm_cnt_q, alarm_cnt_d;
  logic       zero_p_q, zero_p_d;

  logic [2:0] dec_mh, ld_mh_c, ld_sh_c, dec_sh;
  logic [3:0] dec_ml, dec_sl, ld_ml_c, ld_sl_c;
  logic       borrow_sl, borrow_sh, borrow_ml, dec_zero, count_nz;
  logic [7:0] alarm_inc;

  // Borrow chain: each digit only moves when every lower digit wrapped.
  always_comb begin
    borrow_sl = (sl_q == 4'd0);
    dec_sl    = borrow_sl ? 4'd9 : sl_q - 4'd1;
    dec_sh    = borrow_sl ? ((sh_q == 3'd0) ? 3'd5 : sh_q - 3'd1) : sh_q;
    borrow_sh = borrow_sl && (sh_q == 3'd0);
    dec_ml    = borrow_sh ? ((ml_q == 4'd0) ? 4'd9 : ml_q - 4'd1) : ml_q;
    borrow_ml = borrow_sh && (ml_q == 4'd0);
    dec_mh    = borrow_ml ? mh_q - 3'd1 : mh_q;
    dec_zero  = (dec_mh == 3'd0) && (dec_ml == 4'd0) && (dec_sh == 3'd0) && (dec_sl == 4'd0);
    count_nz  = |{mh_q, ml_q, sh_q, sl_q};
    ld_mh_c   = (ld_mh_i > 3'd5) ? 3'd5 : ld_mh_i;
    ld_ml_c   = (ld_ml_i > 4'd9) ? 4'd9 : ld_ml_i;
    ld_sh_c   = (ld_sh_i > 3'd5) ? 3'd5 : ld_sh_i;
    ld_sl_c   = (ld_sl_i > 4'd9) ? 4'd9 : ld_sl_i;
    alarm_inc = alarm_cnt_q + 8'd1;
  end

  always_comb begin
    state_d     = state_q;
    mh_d        = mh_q;
    ml_d        = ml_q;
    sh_d        = sh_q;
    sl_d        = sl_q;
    alarm_cnt_d = alarm_cnt_q;
    zero_p_d    = 1'b0;
    if (clr_i) begin
      state_d     = S_IDLE;
      mh_d        = 3'd0;
      ml_d        = 4'd0;
      sh_d        = 3'd0;
      sl_d        = 4'd0;
      alarm_cnt_d = 8'd0;
    end else if (load_i && state_q != S_RUN) begin
      mh_d = ld_mh_c;
      ml_d = ld_ml_c;
      sh_d = ld_sh_c;
      sl_d = ld_sl_c;
      if (state_q == S_DONE) state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!stop_i && start_i && count_nz) state_d = S_RUN;
        end
        S_RUN: begin
          if (stop_i) begin
            state_d = S_PAUSE;
          end else if (tick_i) begin
            mh_d = dec_mh;
            ml_d = dec_ml;
            sh_d = dec_sh;
            sl_d = dec_sl;
            if (dec_zero) begin
              state_d     = S_DONE;
              zero_p_d    = 1'b1;
              alarm_cnt_d = 8'd0;
            end
          end
        end
        S_PAUSE: begin
          // A preset of 00:00 loaded while paused must not restart the count.
          if (!stop_i && start_i && count_nz) state_d = S_RUN;
        end
        S_DONE: begin
          if (start_i || stop_i) begin
            state_d = S_IDLE;
          end else if (tick_i) begin
            alarm_cnt_d = alarm_inc;
            if (alarm_inc >= ALARM_LIMIT) state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      mh_q        <= 3'd0;
      ml_q        <= 4'd0;
      sh_q        <= 3'd0;
      sl_q        <= 4'd0;
      alarm_cnt_q <= 8'd0;
      zero_p_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mh_q        <= mh_d;
      ml_q        <= ml_d;
      sh_q        <= sh_d;
      sl_q        <= sl_d;
      alarm_cnt_q <= alarm_cnt_d;
      zero_p_q    <= zero_p_d;
    end
  end

  assign mh_o     = mh_q;
  assign ml_o     = ml_q;
  assign sh_o     = sh_q;
  assign sl_o     = sl_q;
  assign busy_o   = (state_q == S_RUN);
  assign alarm_o  = (state_q == S_DONE);
  assign zero_p_o = zero_p_q;

endmodule

// File: tb/tb_min_sec_countdown.sv
// Bench for min_sec_countdown: directed scenarios plus random traffic against a
// seconds-based reference model.
module tb_min_sec_countdown;

  localparam int AT = 10;

  logic       clk, rst_n, tick, clr, load, start, stop;
  logic [2:0] ld_mh, ld_sh, mh, sh;
  logic [3:0] ld_ml, ld_sl, ml, sl;
  logic       busy, zero_p, alarm;
  logic [16:0] dut_vec;

  int checks   = 0;
  int failures = 0;

  // Reference model: remaining time in seconds plus an operating mode.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int   m_secs, m_mode, m_acnt;
  logic m_zp;

  min_sec_countdown #(.ALARM_TICKS(AT)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .tick_i(tick), .clr_i(clr), .load_i(load),
    .ld_mh_i(ld_mh), .ld_ml_i(ld_ml), .ld_sh_i(ld_sh), .ld_sl_i(ld_sl),
    .start_i(start), .stop_i(stop),
    .mh_o(mh), .ml_o(ml), .sh_o(sh), .sl_o(sl),
    .busy_o(busy), .zero_p_o(zero_p), .alarm_o(alarm)
  );

  assign dut_vec = {mh, ml, sh, sl, busy, zero_p, alarm};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] vec(input int m, input int s, input logic b, input logic z, input logic a);
    logic [2:0] vmh, vsh;
    logic [3:0] vml, vsl;
    vmh = 3'(m / 10);
    vml = 4'(m % 10);
    vsh = 3'(s / 10);
    vsl = 4'(s % 10);
    return {vmh, vml, vsh, vsl, b, z, a};
  endfunction

  function automatic logic [16:0] model_vec();
    return vec(m_secs / 60, m_secs % 60, m_mode == M_RUN, m_zp, m_mode == M_DONE);
  endfunction

  function automatic int clampi(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    m_secs = 0; m_mode = M_IDLE; m_acnt = 0; m_zp = 1'b0;
  endtask

  task automatic set_preset(input int a, input int b, input int c, input int d);
    ld_mh = 3'(a); ld_ml = 4'(b); ld_sh = 3'(c); ld_sl = 4'(d);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, land 1 time unit after it.
  task automatic step(input logic t, input logic c, input logic l, input logic s, input logic p);
    tick = t; clr = c; load = l; start = s; stop = p;
    @(posedge clk);
    m_zp = 1'b0;
    if (c) begin
      m_secs = 0; m_mode = M_IDLE; m_acnt = 0;
    end else if (l && m_mode != M_RUN) begin
      m_secs = clampi(int'(ld_mh), 5) * 600 + clampi(int'(ld_ml), 9) * 60
             + clampi(int'(ld_sh), 5) * 10 + clampi(int'(ld_sl), 9);
      if (m_mode == M_DONE) m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE, M_PAUSE: if (!p && s && m_secs != 0) m_mode = M_RUN;
        M_RUN: begin
          if (p) m_mode = M_PAUSE;
          else if (t) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin m_mode = M_DONE; m_acnt = 0; m_zp = 1'b1; end
          end
        end
        default: begin
          if (s || p) m_mode = M_IDLE;
          else if (t) begin
            m_acnt = m_acnt + 1;
            if (m_acnt >= AT) m_mode = M_IDLE;
          end
        end
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick = 0; clr = 0; load = 0; start = 0; stop = 0;
    set_preset(0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== 17'd0) begin failures++; $display("FAIL reset_state: got %h expected %h", dut_vec, 17'd0); end
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    checks++;
    if (dut_vec !== model_vec()) begin failures++; $display("FAIL reset_release: got %h expected %h", dut_vec, model_vec()); end
  endtask

  task automatic test_expiry();
    step(0, 1, 0, 0, 0);
    set_preset(0, 0, 0, 3);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    checks++;
    if (dut_vec !== vec(0, 3, 1, 0, 0)) begin failures++; $display("FAIL expiry_start: got %h expected %h", dut_vec, vec(0, 3, 1, 0, 0)); end
    for (int i = 2; i >= 0; i--) begin
      step(1, 0, 0, 0, 0);
      checks++;
      if (dut_vec !== vec(0, i, i != 0, i == 0, i == 0)) begin
        failures++; $display("FAIL expiry_tick%0d: got %h expected %h", 3 - i, dut_vec, vec(0, i, i != 0, i == 0, i == 0));
      end
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if (dut_vec !== vec(0, 0, 0, 0, 1)) begin failures++; $display("FAIL zero_p_width: got %h expected %h", dut_vec, vec(0, 0, 0, 0, 1)); end
  endtask

  task automatic test_borrow();
    int zcount, zpos;
    step(0, 1, 0, 0, 0);
    set_preset(1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    checks++;
    if (dut_vec !== vec(9, 59, 1, 0, 0)) begin failures++; $display("FAIL borrow_10_00: got %h expected %h", dut_vec, vec(9, 59, 1, 0, 0)); end
    step(0, 1, 0, 0, 0);
    set_preset(0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    checks++;
    if (dut_vec !== vec(0, 59, 1, 0, 0)) begin failures++; $display("FAIL borrow_01_00: got %h expected %h", dut_vec, vec(0, 59, 1, 0, 0)); end
    step(0, 1, 0, 0, 0);
    set_preset(5, 9, 5, 9);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    zcount = 0; zpos = -1;
    for (int i = 1; i <= 3600; i++) begin
      step(1, 0, 0, 0, 0);
      if (zero_p === 1'b1) begin zcount++; zpos = i; end
      checks++;
      if (dut_vec !== model_vec()) begin failures++; $display("FAIL full_run_t%0d: got %h expected %h", i, dut_vec, model_vec()); end
    end
    checks++;
    if (zcount !== 1 || zpos !== 3599) begin failures++; $display("FAIL full_run_zero_p: got count %0d at %0d expected 1 at 3599", zcount, zpos); end
  endtask

  task automatic test_pause();
    step(0, 1, 0, 0, 0);
    set_preset(0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, i == 2);
      checks++;
      if (dut_vec !== vec(0, 10, 0, 0, 0)) begin failures++; $display("FAIL pause_hold%0d: got %h expected %h", i, dut_vec, vec(0, 10, 0, 0, 0)); end
    end
    step(1, 0, 0, 1, 0);
    checks++;
    if (dut_vec !== vec(0, 10, 1, 0, 0)) begin failures++; $display("FAIL resume_no_dec: got %h expected %h", dut_vec, vec(0, 10, 1, 0, 0)); end
    step(1, 0, 0, 0, 0);
    checks++;
    if (dut_vec !== vec(0, 9, 1, 0, 0)) begin failures++; $display("FAIL resume_tick: got %h expected %h", dut_vec, vec(0, 9, 1, 0, 0)); end
    step(1, 0, 0, 1, 1);
    checks++;
    if (dut_vec !== vec(0, 9, 0, 0, 0)) begin failures++; $display("FAIL stop_tick: got %h expected %h", dut_vec, vec(0, 9, 0, 0, 0)); end
  endtask

  task automatic test_alarm();
    step(0, 1, 0, 0, 0);
    set_preset(0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= AT; i++) begin
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      checks++;
      if (alarm !== (i < AT)) begin failures++; $display("FAIL alarm_tick%0d: got %b expected %b", i, alarm, i < AT); end
    end
    checks++;
    if (dut_vec !== 17'd0) begin failures++; $display("FAIL alarm_expire_idle: got %h expected %h", dut_vec, 17'd0); end
    set_preset(0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    checks++;
    if (dut_vec !== 17'd0) begin failures++; $display("FAIL alarm_stop_ack: got %h expected %h", dut_vec, 17'd0); end
  endtask

  task automatic test_load();
    step(0, 1, 0, 0, 0);
    set_preset(7, 12, 6, 15);
    step(0, 0, 1, 0, 0);
    checks++;
    if (dut_vec !== vec(59, 59, 0, 0, 0)) begin failures++; $display("FAIL load_clamp: got %h expected %h", dut_vec, vec(59, 59, 0, 0, 0)); end
    step(0, 0, 0, 1, 0);
    set_preset(1, 2, 3, 4);
    step(0, 0, 1, 0, 0);
    checks++;
    if (dut_vec !== vec(59, 59, 1, 0, 0)) begin failures++; $display("FAIL load_in_run: got %h expected %h", dut_vec, vec(59, 59, 1, 0, 0)); end
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    checks++;
    if (dut_vec !== 17'd0) begin failures++; $display("FAIL start_at_zero: got %h expected %h", dut_vec, 17'd0); end
    step(0, 1, 1, 1, 0);
    checks++;
    if (dut_vec !== 17'd0) begin failures++; $display("FAIL clr_load_start: got %h expected %h", dut_vec, 17'd0); end
  endtask

  task automatic test_async_reset();
    step(0, 1, 0, 0, 0);
    set_preset(0, 5, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== 17'd0) begin failures++; $display("FAIL async_reset: got %h expected %h", dut_vec, 17'd0); end
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0, 0);
    checks++;
    if (dut_vec !== model_vec()) begin failures++; $display("FAIL after_async_reset: got %h expected %h", dut_vec, model_vec()); end
  endtask

  task automatic test_random();
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(1, 0) == 1) set_preset(0, 0, $urandom_range(1, 0), $urandom_range(15, 0));
      else set_preset($urandom_range(7, 0), $urandom_range(15, 0), $urandom_range(7, 0), $urandom_range(15, 0));
      step($urandom_range(1, 0) == 1, $urandom_range(99, 0) < 2, $urandom_range(99, 0) < 6,
           $urandom_range(99, 0) < 12, $urandom_range(99, 0) < 5);
      checks++;
      if (dut_vec !== model_vec()) begin failures++; $display("FAIL random_c%0d: got %h expected %h", i, dut_vec, model_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_expiry();
    test_borrow();
    test_pause();
    test_alarm();
    test_load();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
